// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the pipelined main memory among I-fill, D-fill and store requesters
module mem_arbiter #(
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icache_req,
  input  logic [15:0] icache_addr,
  input  logic        dcache_req,
  input  logic [15:0] dcache_addr,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_out,
  output logic        icache_busy,
  output logic        dcache_busy,
  output logic        icache_wvalid,
  output logic        dcache_wvalid,
  output logic [2:0]  block_num,
  output logic        icache_done,
  output logic        dcache_done,
  output logic        wr_done
);

  localparam logic [3:0] WPB = 4'(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {IDLE, IFILL, DFILL, WRITE} state_t;

  state_t      state, state_nx;
  logic [3:0]  issue_cnt, ret_cnt;
  logic        last_i;          // set after a D-fill: the I-cache wins the next tie
  logic [11:0] base_addr;
  logic [15:0] wr_addr_q, wr_data_q;
  logic        icache_done_q, dcache_done_q;
  logic        fill, issuing, ret_ok, last_ret;

  // Only the block part of a miss address matters; the word offset is regenerated.
  logic unused_offsets;
  assign unused_offsets = ^{icache_addr[3:0], dcache_addr[3:0]};

  always_comb begin
    fill     = (state == IFILL) || (state == DFILL);
    issuing  = fill && (issue_cnt < WPB);
    ret_ok   = fill && mem_data_valid && (ret_cnt < WPB);
    last_ret = ret_ok && (ret_cnt == WPB - 4'd1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (wr_req)                        state_nx = WRITE;
        else if (icache_req && dcache_req) state_nx = last_i ? IFILL : DFILL;
        else if (dcache_req)               state_nx = DFILL;
        else if (icache_req)               state_nx = IFILL;
      end
      IFILL, DFILL: if (last_ret) state_nx = IDLE;
      WRITE:        state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_enable    = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = 16'h0000;
    mem_data_out  = 16'h0000;
    icache_busy   = (state == IFILL);
    dcache_busy   = (state == DFILL);
    icache_wvalid = (state == IFILL) && ret_ok;
    dcache_wvalid = (state == DFILL) && ret_ok;
    block_num     = ret_ok ? ret_cnt[2:0] : 3'd0;
    icache_done   = icache_done_q;
    dcache_done   = dcache_done_q;
    wr_done       = (state == WRITE);
    if (state == WRITE) begin
      mem_enable   = 1'b1;
      mem_wr       = 1'b1;
      mem_addr     = wr_addr_q;
      mem_data_out = wr_data_q;
    end else if (issuing) begin
      mem_enable = 1'b1;
      mem_addr   = {base_addr, issue_cnt[2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      issue_cnt     <= 4'd0;
      ret_cnt       <= 4'd0;
      last_i        <= 1'b0;
      base_addr     <= 12'h000;
      wr_addr_q     <= 16'h0000;
      wr_data_q     <= 16'h0000;
      icache_done_q <= 1'b0;
      dcache_done_q <= 1'b0;
    end else begin
      state         <= state_nx;
      icache_done_q <= (state == IFILL) && last_ret;
      dcache_done_q <= (state == DFILL) && last_ret;
      if (state == IDLE) begin
        if (wr_req) begin
          wr_addr_q <= wr_addr;
          wr_data_q <= wr_data;
        end else if (state_nx == IFILL) begin
          base_addr <= icache_addr[15:4];
        end else if (state_nx == DFILL) begin
          base_addr <= dcache_addr[15:4];
        end
      end
      if (fill) begin
        if (last_ret) begin
          issue_cnt <= 4'd0;
          ret_cnt   <= 4'd0;
          last_i    <= (state == DFILL);
        end else begin
          if (issuing) issue_cnt <= issue_cnt + 4'd1;
          if (ret_ok)  ret_cnt   <= ret_cnt + 4'd1;
        end
      end
    end
  end

endmodule
